// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART definitions: FSM state encoding, parity modes and the
//           baud divider calculation. Used by both transmitter and receiver.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Line-side bit phases of a frame
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_START  = 3'b001,
    S_DATA   = 3'b010,
    S_PARITY = 3'b011,
    S_STOP   = 3'b100
  } state_t;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to the nearest integer
  function automatic int calc_div(input int f, input int baud);
    return (f + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_baud_gen
// Purpose : Free-running 0..DIV-1 counter producing a one-clock tick on the
//           last count. clr restarts the count so bit timing aligns to the
//           moment a frame is accepted.
// Rev     : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on request, wrap at DIV-1, hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_param
// Purpose : Parametrised UART transmitter. Accepts one word per valid/ready
//           handshake and sends start, DATA_BITS data (LSB first), optional
//           parity and STOP_BITS stop bits, each held DIV clocks.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int F         = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int DIV   = calc_div(F, BAUD);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Elaboration-time parameter sanity
  if (DIV < 2) begin : g_chk_div
    $error("uart_tx_param: F/BAUD must give a divider of at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] shadow_q;
  logic [DATA_BITS-1:0] shadow_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 tick;
  logic                 accept;
  logic                 par_bit;

  assign ready  = (state_q == S_IDLE);
  assign busy   = !ready;
  assign accept = valid && ready;
  assign tx     = tx_q;

  // Parity always derived from the captured word, never the live input
  assign par_bit = (PARITY == PAR_ODD) ? ~^shadow_q : ^shadow_q;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

  // Next-state, bit index, shadow capture and next line level
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d  = S_START;
          shadow_d = data;
          idx_d    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        // idx counts stop bits here so two stop bits need no extra counter
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Line level is registered, so derive it from the state being entered
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shadow_d[idx_d];
      S_PARITY: tx_d = par_bit;
      default:  tx_d = 1'b1;
    endcase
  end

  // State, index, shadow and line registers; reset forces the line idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that serialises one word per handshake: start bit, configurable data bits (LSB first), optional parity, and 1 or 2 stop bits.
- Baud timing comes from F/BAUD through an internal divider that restarts on every accepted frame.
- Input data is captured in a shadow register at acceptance, so source changes mid-frame do not corrupt the frame.
- Sits between the system-side byte producer (FIFO or CPU register) and the FPGA tx pin.

Parameters:
F, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
data  input  DATA_BITS  word to send; sampled only at acceptance
valid  input  1  producer has a word on data
ready  output  1  transmitter can accept; high only in IDLE
tx  output  1  serial line, idle high, registered
busy  output  1  high from acceptance until the frame ends

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, tx=1, ready=1, busy=0, divider=0, bit index=0. Reset mid-frame aborts the frame immediately; tx returns high with no glitch low.
- Derived constants:
  - DIV = (F + BAUD/2) / BAUD, integer, rounded; DIV >= 2 is required (elaboration-time check).
  - NBITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- States: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Acceptance occurs at rising edge E0 where valid && ready. At E0:
  - shadow <= data; state <= START; tx <= 0; ready <= 0; busy <= 1; divider <= 0.
  - When valid is low in IDLE: no change, tx stays 1.
- Bit timing:
  - Each bit is held on tx for exactly DIV clk cycles.
  - Bit k is driven from edge E0+k*DIV up to edge E0+(k+1)*DIV.
  - The divider counts 0..DIV-1 and emits a tick when it reaches DIV-1; the state and bit index advance on the tick.
- DATA: tx = shadow[idx], idx 0..DATA_BITS-1, LSB first; idx wraps to 0 when leaving DATA.
- PARITY:
  - Even: tx = ^shadow.
  - Odd: tx = ~^shadow.
  - Computed from shadow only, never from the live data input.
- STOP: tx = 1 for STOP_BITS*DIV cycles.
- Frame end: at edge E0+NBITS*DIV, state <= IDLE, ready <= 1, busy <= 0; tx stays 1.
  - The earliest next acceptance is at edge E0+NBITS*DIV+1, so frames are separated by at least 1 clk of extra idle-high.
- Changes on data or valid while busy are ignored; valid held high continuously produces back-to-back frames with the 1-clk gap.
- ready and busy are complementary at all times.
- Width rules:
  - divider is $clog2(DIV) bits; idx is $clog2(DATA_BITS) bits.
  - No arithmetic overflow is allowed; the divider compare is an equality compare to DIV-1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants S_IDLE, S_START, S_DATA, S_PARITY, S_STOP (2'b00..3'b100, 3 bits);
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - a constant function that computes DIV from F and BAUD.
- The package is to be reused by the matching receiver.
- One sub-module, uart_baud_gen: parameter DIV; inputs clk, rst, clr, en; output tick (one clk wide when the count reaches DIV-1); clr zeroes the count.
- The FSM, shadow register, and tx register live in uart_tx_param.

Test Plan:
- F=1000, BAUD=100 (DIV=10), 8N1. Send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 10 clks; ready returns 1 exactly 100 clks after acceptance; busy high for those 100 clks.
- DIV=10, PARITY=2 (even). Send 0x07 -> parity bit 1. With PARITY=1 (odd), same data -> parity bit 0. Frame length 110 clks.
- DIV=10, DATA_BITS=7, STOP_BITS=2. Send 0x41 -> 7 data bits 1,0,0,0,0,0,1, then tx high for 20 clks before ready.
- valid held high with data 0xA5 then 0x3C presented in consecutive frames -> two complete frames, exactly 1 clk of idle-high between the stop-bit end and the next start bit; data toggled mid-frame has no effect on tx.
- Assert rst for 1 clk during data bit 3 -> tx=1 asynchronously, ready=1, busy=0. The next send of 0xFF produces a clean full frame.
- Idle with valid=0 for 500 clks -> tx stays 1, ready stays 1, no ticks affect the outputs.
